// File: rtl/segment_led_capture.sv
// Receive side of a scanned (multiplexed) 7-segment display bus.
// The segment and digit-select lines are synchronized and their polarity is
// normalized. A digit pattern is stored only after the combined bus has held
// the same value for SETTLE_CYCLES samples, so ghosting is rejected during
// digit switch-over. Frame completion and loss of scanning are also reported.

module segment_led_capture #(
   parameter int   NUMBER_OF_SEGMENTS = 8,
   parameter int   NUMBER_OF_DIGITS   = 4,
   parameter logic CATHODE_COMMON     = 1'b1,
   parameter logic SEGMENT_ACTIVE_LOW = 1'b0,
   parameter int   SETTLE_CYCLES      = 4,
   parameter int   TIMEOUT_CYCLES     = 65535
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUMBER_OF_SEGMENTS-1:0] segment_in,
   input  logic [NUMBER_OF_DIGITS-1:0]   digit_selector_in,
   output logic [NUMBER_OF_SEGMENTS-1:0] digits_out [0:NUMBER_OF_DIGITS-1],
   output logic [NUMBER_OF_DIGITS-1:0]   digit_valid_out,
   output logic                          frame_done_out,
   output logic                          stale_out
);

   localparam int NSEG      = NUMBER_OF_SEGMENTS;
   localparam int NDIG      = NUMBER_OF_DIGITS;
   localparam int SAMPLE_W  = NSEG + NDIG;
   localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_PRE = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [NSEG-1:0]      seg_meta_q, seg_meta_d;
   logic [NSEG-1:0]      seg_sync_q, seg_sync_d;
   logic [NDIG-1:0]      sel_meta_q, sel_meta_d;
   logic [NDIG-1:0]      sel_sync_q, sel_sync_d;
   logic [SAMPLE_W-1:0]  prev_sample_q, prev_sample_d;
   logic [1:0]           state_q, state_d;
   logic [SETTLE_W-1:0]  settle_count_q, settle_count_d;
   logic [TIMEOUT_W-1:0] timeout_count_q, timeout_count_d;
   logic [NSEG-1:0]      digits_q [0:NDIG-1];
   logic [NSEG-1:0]      digits_d [0:NDIG-1];
   logic [NDIG-1:0]      digit_valid_q, digit_valid_d;
   logic [NDIG-1:0]      mask_q, mask_d;
   logic                 frame_done_q, frame_done_d;
   logic                 stale_q, stale_d;

   logic [NDIG-1:0]      sel_norm;
   logic [NSEG-1:0]      seg_norm;
   logic [SAMPLE_W-1:0]  sample;
   logic                 sel_valid;
   logic                 sample_changed;
   logic                 latch;
   logic [NDIG-1:0]      mask_next;

   // Two-stage synchronizer feed plus the history used to detect a steady bus.
   always_comb begin
      seg_meta_d    = segment_in;
      seg_sync_d    = seg_meta_q;
      sel_meta_d    = digit_selector_in;
      sel_sync_d    = sel_meta_q;
      sel_norm      = CATHODE_COMMON ? ~sel_sync_q : sel_sync_q;
      seg_norm      = SEGMENT_ACTIVE_LOW ? ~seg_sync_q : seg_sync_q;
      sample        = {sel_norm, seg_norm};
      sel_valid     = $onehot(sel_norm);
      sample_changed = (sample != prev_sample_q);
      prev_sample_d = sample;
   end

   // Settle tracking: a valid sample starts a run, and the run latches once it reaches SETTLE_CYCLES.
   always_comb begin
      state_d        = state_q;
      settle_count_d = settle_count_q;
      latch          = 1'b0;
      if (!sel_valid) begin
         state_d        = ST_WAIT;
         settle_count_d = '0;
      end else if (sample_changed || (state_q != ST_SETTLE && state_q != ST_HOLD)) begin
         if (SETTLE_CYCLES == 1) begin
            latch          = 1'b1;
            state_d        = ST_HOLD;
            settle_count_d = '0;
         end else begin
            state_d        = ST_SETTLE;
            settle_count_d = SETTLE_W'(1);
         end
      end else if (state_q == ST_SETTLE) begin
         if (settle_count_q == SETTLE_LAST) begin
            latch          = 1'b1;
            state_d        = ST_HOLD;
            settle_count_d = '0;
         end else begin
            settle_count_d = settle_count_q + 1'b1;
         end
      end
   end

   // Capture storage, frame mask and stale timeout bookkeeping.
   always_comb begin
      for (int d = 0; d < NDIG; d++) begin
         digits_d[d] = digits_q[d];
      end
      digit_valid_d   = digit_valid_q;
      mask_d          = mask_q;
      frame_done_d    = 1'b0;
      stale_d         = stale_q;
      timeout_count_d = timeout_count_q;
      mask_next       = mask_q | sel_norm;
      if (latch) begin
         for (int d = 0; d < NDIG; d++) begin
            if (sel_norm[d]) begin
               digits_d[d] = seg_norm;
            end
         end
         digit_valid_d   = digit_valid_q | sel_norm;
         timeout_count_d = '0;
         stale_d         = 1'b0;
         if (&mask_next) begin
            frame_done_d = 1'b1;
            mask_d       = '0;
         end else begin
            mask_d = mask_next;
         end
      end else if (timeout_count_q != TIMEOUT_MAX) begin
         timeout_count_d = timeout_count_q + 1'b1;
         if (timeout_count_q == TIMEOUT_PRE) begin
            stale_d       = 1'b1;
            digit_valid_d = '0;
            mask_d        = '0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         seg_meta_q      <= '0;
         seg_sync_q      <= '0;
         sel_meta_q      <= '0;
         sel_sync_q      <= '0;
         prev_sample_q   <= '0;
         state_q         <= ST_WAIT;
         settle_count_q  <= '0;
         timeout_count_q <= '0;
         for (int d = 0; d < NDIG; d++) begin
            digits_q[d] <= '0;
         end
         digit_valid_q   <= '0;
         mask_q          <= '0;
         frame_done_q    <= 1'b0;
         stale_q         <= 1'b0;
      end else begin
         seg_meta_q      <= seg_meta_d;
         seg_sync_q      <= seg_sync_d;
         sel_meta_q      <= sel_meta_d;
         sel_sync_q      <= sel_sync_d;
         prev_sample_q   <= prev_sample_d;
         state_q         <= state_d;
         settle_count_q  <= settle_count_d;
         timeout_count_q <= timeout_count_d;
         for (int d = 0; d < NDIG; d++) begin
            digits_q[d] <= digits_d[d];
         end
         digit_valid_q   <= digit_valid_d;
         mask_q          <= mask_d;
         frame_done_q    <= frame_done_d;
         stale_q         <= stale_d;
      end
   end

   assign digits_out      = digits_q;
   assign digit_valid_out = digit_valid_q;
   assign frame_done_out  = frame_done_q;
   assign stale_out       = stale_q;

endmodule

// File: tb/tb_segment_led_capture.sv
// Testbench for segment_led_capture: directed scenarios plus randomized
// scanning, checked against a run-length based reference model.

module tb_segment_led_capture;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] seg_in;
   logic [3:0] sel_in;
   logic [7:0] digits [0:3];
   logic [3:0] dvalid;
   logic       frame;
   logic       stale;

   logic       p_reset;
   logic [7:0] p_seg;
   logic [3:0] p_sel;
   logic [7:0] p_digits [0:3];
   logic [3:0] p_valid;
   logic       p_frame;
   logic       p_stale;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state
   logic [7:0]  m_digits [0:3];
   logic [3:0]  m_valid, m_mask;
   logic        m_frame, m_stale;
   int          m_idle, m_run;
   logic        m_have_prev;
   logic [11:0] m_prev, m_sample;
   logic [3:0]  m_sel_d1, m_sel_d2, m_sel_n;
   logic [7:0]  m_seg_d1, m_seg_d2, m_seg_n;

   logic [43:0] obs_flat, exp_flat;
   assign obs_flat = {digits[0], digits[1], digits[2], digits[3], dvalid, frame, stale};
   assign exp_flat = {m_digits[0], m_digits[1], m_digits[2], m_digits[3], m_valid, m_frame, m_stale};

   always #5 clock = ~clock;

   segment_led_capture #(
      .NUMBER_OF_SEGMENTS(8), .NUMBER_OF_DIGITS(4), .CATHODE_COMMON(1'b1),
      .SEGMENT_ACTIVE_LOW(1'b0), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset), .segment_in(seg_in), .digit_selector_in(sel_in),
      .digits_out(digits), .digit_valid_out(dvalid), .frame_done_out(frame), .stale_out(stale)
   );

   segment_led_capture #(
      .NUMBER_OF_SEGMENTS(8), .NUMBER_OF_DIGITS(4), .CATHODE_COMMON(1'b0),
      .SEGMENT_ACTIVE_LOW(1'b1), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(65535)
   ) dut_pol (
      .clock(clock), .reset(p_reset), .segment_in(p_seg), .digit_selector_in(p_sel),
      .digits_out(p_digits), .digit_valid_out(p_valid), .frame_done_out(p_frame), .stale_out(p_stale)
   );

   // Reference model: a digit is captured when a one-hot select sample has been seen
   // SETTLE times in a row; the bus reaches the capture logic two clocks late.
   always @(posedge clock) begin
      if (reset) begin
         for (int d = 0; d < 4; d++) m_digits[d] = '0;
         m_valid = '0; m_mask = '0; m_frame = 1'b0; m_stale = 1'b0;
         m_idle = 0; m_run = 0; m_have_prev = 1'b0; m_prev = '0;
         m_sel_d1 = '0; m_sel_d2 = '0; m_seg_d1 = '0; m_seg_d2 = '0;
      end else begin
         m_sel_n  = ~m_sel_d2;
         m_seg_n  = m_seg_d2;
         m_sample = {m_sel_n, m_seg_n};
         if (m_have_prev && m_sample == m_prev) m_run = m_run + 1;
         else m_run = 1;
         m_prev = m_sample;
         m_have_prev = 1'b1;
         m_frame = 1'b0;
         if ($countones(m_sel_n) == 1 && m_run == SETTLE) begin
            for (int d = 0; d < 4; d++) begin
               if (m_sel_n[d]) begin
                  m_digits[d] = m_seg_n;
                  m_valid[d]  = 1'b1;
                  m_mask[d]   = 1'b1;
               end
            end
            if (m_mask == 4'hF) begin
               m_frame = 1'b1;
               m_mask  = '0;
            end
            m_idle  = 0;
            m_stale = 1'b0;
         end else if (m_idle < TIMEOUT) begin
            m_idle = m_idle + 1;
            if (m_idle == TIMEOUT) begin
               m_stale = 1'b1;
               m_valid = '0;
               m_mask  = '0;
            end
         end
         m_sel_d2 = m_sel_d1; m_sel_d1 = sel_in;
         m_seg_d2 = m_seg_d1; m_seg_d1 = seg_in;
      end
   end

   task automatic drive(input logic [3:0] sel, input logic [7:0] seg);
      sel_in = sel;
      seg_in = seg;
   endtask

   task automatic test_reset;
      reset = 1'b1; p_reset = 1'b1;
      drive(4'b1111, 8'h00);
      p_sel = 4'b0000; p_seg = 8'hFF;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_compared++;
      if (obs_flat !== 44'h0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs_flat, 44'h0);
      end
      reset = 1'b0; p_reset = 1'b0;
      @(negedge clock);
      n_compared++;
      if (obs_flat !== exp_flat || dvalid !== 4'b0000 || stale !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_release: got %h expected %h", obs_flat, exp_flat);
      end
   endtask

   task automatic test_single_digit;
      drive(4'b1110, 8'h3F);
      for (int e = 0; e <= 5; e++) begin
         @(negedge clock);
         n_compared++;
         if (obs_flat !== exp_flat) begin
            n_mismatched++;
            $display("[TB] FAIL single_model e=%0d: got %h expected %h", e, obs_flat, exp_flat);
         end
         if (e == 4) begin
            n_compared++;
            if (digits[0] !== 8'h00) begin
               n_mismatched++;
               $display("[TB] FAIL single_early: got %h expected %h", digits[0], 8'h00);
            end
         end
      end
      n_compared++;
      if (digits[0] !== 8'h3F || dvalid !== 4'b0001) begin
         n_mismatched++;
         $display("[TB] FAIL single_latch: got %h/%b expected 3f/0001", digits[0], dvalid);
      end
   endtask

   task automatic test_scan;
      logic [7:0] pats [0:3];
      logic [3:0] one;
      int pulses;
      pats[0] = 8'h06; pats[1] = 8'h5B; pats[2] = 8'h4F; pats[3] = 8'h66;
      pulses = 0;
      for (int d = 0; d < 4; d++) begin
         one = 4'b0001 << d;
         drive(~one, pats[d]);
         repeat (8) begin
            @(negedge clock);
            if (frame === 1'b1) pulses++;
            n_compared++;
            if (obs_flat !== exp_flat) begin
               n_mismatched++;
               $display("[TB] FAIL scan_model d=%0d: got %h expected %h", d, obs_flat, exp_flat);
            end
         end
      end
      n_compared++;
      if (pulses != 1) begin
         n_mismatched++;
         $display("[TB] FAIL scan_frame_pulses: got %0d expected 1", pulses);
      end
      for (int d = 0; d < 4; d++) begin
         n_compared++;
         if (digits[d] !== pats[d]) begin
            n_mismatched++;
            $display("[TB] FAIL scan_pattern d=%0d: got %h expected %h", d, digits[d], pats[d]);
         end
      end
      n_compared++;
      if (dvalid !== 4'b1111) begin
         n_mismatched++;
         $display("[TB] FAIL scan_valid: got %b expected 1111", dvalid);
      end
   endtask

   task automatic test_ghosting;
      drive(4'b1100, 8'h66);
      repeat (2) @(negedge clock);
      drive(4'b1110, 8'hFF);
      repeat (3) @(negedge clock);
      drive(4'b1110, 8'h06);
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         n_compared++;
         if (obs_flat !== exp_flat || digits[0] === 8'hFF || digits[2] !== 8'h4F) begin
            n_mismatched++;
            $display("[TB] FAIL ghost_cycle c=%0d: got %h expected %h", c, obs_flat, exp_flat);
         end
      end
      n_compared++;
      if ({digits[0], digits[1], digits[2], digits[3]} !== 32'h065B4F66) begin
         n_mismatched++;
         $display("[TB] FAIL ghost_final: got %h expected 065b4f66",
                  {digits[0], digits[1], digits[2], digits[3]});
      end
   endtask

   task automatic test_timeout;
      drive(4'b1101, 8'h5B);
      for (int e = 0; e <= 24; e++) begin
         @(negedge clock);
         if (e == 7) drive(4'b1111, 8'h00);
         n_compared++;
         if (stale !== (e >= 21) || obs_flat !== exp_flat) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_stale e=%0d: got %b expected %b", e, stale, (e >= 21));
         end
      end
      n_compared++;
      if (dvalid !== 4'b0000 || digits[1] !== 8'h5B) begin
         n_mismatched++;
         $display("[TB] FAIL timeout_outputs: got %b/%h expected 0000/5b", dvalid, digits[1]);
      end
      drive(4'b1011, 8'h4F);
      for (int e = 0; e <= 7; e++) begin
         @(negedge clock);
         n_compared++;
         if (stale !== (e < 5) || obs_flat !== exp_flat) begin
            n_mismatched++;
            $display("[TB] FAIL resume_stale e=%0d: got %b expected %b", e, stale, (e < 5));
         end
      end
      n_compared++;
      if (dvalid !== 4'b0100) begin
         n_mismatched++;
         $display("[TB] FAIL resume_valid: got %b expected 0100", dvalid);
      end
   endtask

   task automatic test_polarity;
      p_sel = 4'b0100; p_seg = 8'hC0;
      for (int e = 0; e <= 5; e++) begin
         @(negedge clock);
         if (e == 4) begin
            n_compared++;
            if (p_digits[2] !== 8'h00) begin
               n_mismatched++;
               $display("[TB] FAIL polarity_early: got %h expected 00", p_digits[2]);
            end
         end
      end
      n_compared++;
      if (p_digits[2] !== 8'h3F || p_valid !== 4'b0100 || p_digits[0] !== 8'h00
          || p_frame !== 1'b0 || p_stale !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL polarity_latch: got %h/%b expected 3f/0100", p_digits[2], p_valid);
      end
   endtask

   task automatic test_reset_midsettle;
      drive(4'b0111, 8'h7F);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_compared++;
      if (obs_flat !== 44'h0) begin
         n_mismatched++;
         $display("[TB] FAIL midsettle_reset: got %h expected 0", obs_flat);
      end
      reset = 1'b0;
      for (int r = 0; r <= 5; r++) begin
         @(negedge clock);
         n_compared++;
         if (obs_flat !== exp_flat || digits[3] !== ((r >= 5) ? 8'h7F : 8'h00)) begin
            n_mismatched++;
            $display("[TB] FAIL midsettle_relatch r=%0d: got %h expected %h", r, obs_flat, exp_flat);
         end
      end
      n_compared++;
      if (dvalid !== 4'b1000) begin
         n_mismatched++;
         $display("[TB] FAIL midsettle_valid: got %b expected 1000", dvalid);
      end
   endtask

   task automatic test_random;
      int kind, hold;
      logic [3:0] sel;
      logic [7:0] seg;
      for (int s = 0; s < 150; s++) begin
         kind = $urandom_range(0, 9);
         hold = $urandom_range(1, 7);
         seg  = 8'($urandom_range(0, 255));
         if (kind < 7) sel = ~(4'b0001 << $urandom_range(0, 3));
         else if (kind == 7) sel = 4'b1111;
         else if (kind == 8) sel = 4'($urandom_range(0, 15));
         else begin
            sel  = 4'b1111;
            hold = 20;
         end
         drive(sel, seg);
         reset = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < hold; c++) begin
            @(negedge clock);
            reset = 1'b0;
            n_compared++;
            if (obs_flat !== exp_flat) begin
               n_mismatched++;
               $display("[TB] FAIL random s=%0d c=%0d: got %h expected %h", s, c, obs_flat, exp_flat);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_scan();
      test_ghosting();
      test_timeout();
      test_polarity();
      test_reset_midsettle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
